data_mem_pipe: RTL and testbench

//  Parametrised single-port data memory for the CPU load/store stage; next generation of the flat 32-bit Data_mem.

---
 rtl/data_mem_pkg.sv | 23 ++
 rtl/data_mem_load_fmt.sv | 35 +++
 rtl/data_mem_pipe.sv | 150 +++++++++++++++
 tb/tb_data_mem_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants, FSM state type and helpers for the data memory pipeline.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << r) < 64'(v)) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/data_mem_load_fmt.sv
// Load result formatter: aligns the addressed bytes to bit 0, then sign- or zero-extends by access size.
module data_mem_load_fmt
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OFF_W  = 2
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [1:0]        size_i,
    input  logic              signed_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] shifted;
    logic              msb;
    logic              ext;
    int unsigned       nbits;

    always_comb begin
        shifted = word_i >> {off_i, 3'b000};
        case (size_i)
            SZ_BYTE: begin nbits = 8;      msb = shifted[7];        end
            SZ_HALF: begin nbits = 16;     msb = shifted[15];       end
            SZ_WORD: begin nbits = 32;     msb = shifted[31];       end
            default: begin nbits = DATA_W; msb = shifted[DATA_W-1]; end
        endcase
        ext    = signed_i & msb;
        data_o = '0;
        for (int unsigned b = 0; b < DATA_W; b++) begin
            data_o[b] = (b < nbits) ? shifted[b] : ext;
        end
    end

endmodule

// File: rtl/data_mem_pipe.sv
// Single-port data memory with valid/ready requests, byte-lane stores, extended loads,
// error responses, fixed read latency and an optional zero-fill sweep after reset.
module data_mem_pipe
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned READ_LAT     = 1,
    parameter int unsigned CLEAR_ON_RST = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Req_valid,
    output logic              Req_ready,
    input  logic              Req_we,
    input  logic [1:0]        Req_size,
    input  logic              Req_signed,
    input  logic [ADDR_W-1:0] Data_address,
    input  logic [DATA_W-1:0] Data_in,
    output logic              Rsp_valid,
    output logic              Rsp_err,
    output logic [DATA_W-1:0] Data_out
);

    localparam int unsigned BYTES  = DATA_W / 8;
    localparam int unsigned OFF_W  = clog2(BYTES);
    localparam int unsigned WORD_W = clog2(DEPTH);
    localparam logic [1:0]  MAX_SZ = 2'(OFF_W);

    state_e              state_q;
    logic [WORD_W-1:0]   sweep_q;
    logic                ready_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_INIT : ST_RUN;
            sweep_q <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + WORD_W'(1);
                    if (sweep_q == WORD_W'(DEPTH - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: ready_q <= 1'b1;
                default: state_q <= ST_RUN;
            endcase
        end
    end

    logic [OFF_W-1:0]  off;
    logic [WORD_W-1:0] word_idx;
    logic [OFF_W-1:0]  align_mask;
    logic [BYTES-1:0]  size_be;
    logic [BYTES-1:0]  byte_en;
    logic [DATA_W-1:0] wdata;
    logic              err;
    logic              accept;
    logic              wr_en;

    always_comb begin
        off      = Data_address[OFF_W-1:0];
        word_idx = Data_address[OFF_W +: WORD_W];
        align_mask = '0;
        for (int unsigned i = 0; i < OFF_W; i++) begin
            align_mask[i] = (i < 32'(Req_size));
        end
        size_be = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            size_be[i] = (i < (32'd1 << Req_size));
        end
        err = (Req_size > MAX_SZ)
            | ((off & align_mask) != '0)
            | ((Data_address >> (OFF_W + WORD_W)) != '0);
        byte_en = size_be << off;
        wdata   = Data_in << {off, 3'b000};
        accept  = Req_valid & ready_q;
        wr_en   = accept & Req_we & ~err;
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] ld_data;

    // The sweep owns the write port during INIT; requests are blocked then by ready_q.
    always_ff @(posedge Clk) begin
        if (state_q == ST_INIT) begin
            mem_q[sweep_q] <= '0;
        end else if (wr_en) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rd_word = mem_q[word_idx];

    data_mem_load_fmt #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_fmt (
        .word_i   (rd_word),
        .off_i    (off),
        .size_i   (Req_size),
        .signed_i (Req_signed),
        .data_o   (ld_data)
    );

    logic              vld_d;
    logic              err_d;
    logic [DATA_W-1:0] dat_d;
    logic              vld_q [READ_LAT];
    logic              err_q [READ_LAT];
    logic [DATA_W-1:0] dat_q [READ_LAT];

    always_comb begin
        vld_d = accept;
        err_d = accept & err;
        dat_d = (accept & ~Req_we & ~err) ? ld_data : '0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int unsigned i = 0; i < READ_LAT; i++) begin
                vld_q[i] <= 1'b0;
                err_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= vld_d;
            err_q[0] <= err_d;
            dat_q[0] <= dat_d;
            for (int unsigned i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                err_q[i] <= err_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign Req_ready = ready_q;
    assign Rsp_valid = vld_q[READ_LAT-1];
    assign Rsp_err   = err_q[READ_LAT-1];
    assign Data_out  = dat_q[READ_LAT-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed and random checks of data_mem_pipe against a byte-array reference model.
module tb_data_mem_pipe;

    localparam int unsigned LAT    = 2;
    localparam int unsigned DEPTH  = 4096;
    localparam int unsigned NBYTES = DEPTH * 4;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Req_valid;
    logic        Req_ready;
    logic        Req_we;
    logic [1:0]  Req_size;
    logic        Req_signed;
    logic [31:0] Data_address;
    logic [31:0] Data_in;
    logic        Rsp_valid;
    logic        Rsp_err;
    logic [31:0] Data_out;

    always #5 Clk = ~Clk;

    data_mem_pipe #(
        .DATA_W       (32),
        .DEPTH        (DEPTH),
        .ADDR_W       (32),
        .READ_LAT     (LAT),
        .CLEAR_ON_RST (1)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Req_valid    (Req_valid),
        .Req_ready    (Req_ready),
        .Req_we       (Req_we),
        .Req_size     (Req_size),
        .Req_signed   (Req_signed),
        .Data_address (Data_address),
        .Data_in      (Data_in),
        .Rsp_valid    (Rsp_valid),
        .Rsp_err      (Rsp_err),
        .Data_out     (Data_out)
    );

    typedef struct {
        int unsigned due;
        logic        err;
        logic [31:0] data;
    } rsp_t;

    int          checks = 0;
    int          errors = 0;
    int unsigned edges = 0;
    int unsigned init_left = 0;
    logic        exp_ready = 1'b0;
    rsp_t        exp_q[$];
    byte unsigned ref_mem [NBYTES];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int unsigned i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
    endtask

    // Reference behaviour: byte-addressed little-endian memory, plain arithmetic.
    task automatic model_req(input logic we, input logic [1:0] sz, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] data);
        rsp_t        r;
        int unsigned nb;
        logic [63:0] val;
        nb    = 32'd1 << sz;
        r.due = edges + LAT - 1;
        r.err = 1'b0;
        r.data = 32'h0;
        if (sz > 2 || (addr % nb) != 0 || addr >= NBYTES) begin
            r.err = 1'b1;
        end else if (we) begin
            for (int unsigned k = 0; k < nb; k++) ref_mem[addr + k] = 8'((data >> (8 * k)) & 32'hFF);
        end else begin
            val = 64'h0;
            for (int unsigned k = 0; k < nb; k++) val = val | (64'(ref_mem[addr + k]) << (8 * k));
            if (sgn && val[8 * nb - 1]) val = val | ~((64'd1 << (8 * nb)) - 64'd1);
            r.data = val[31:0];
        end
        exp_q.push_back(r);
    endtask

    task automatic check_rsp();
        logic exp_v;
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == edges);
        check("rsp_valid", {31'b0, Rsp_valid}, {31'b0, exp_v});
        if (exp_v) begin
            check("rsp_err", {31'b0, Rsp_err}, {31'b0, exp_q[0].err});
            check("data_out", Data_out, exp_q[0].data);
            void'(exp_q.pop_front());
        end
    endtask

    // One clock cycle: entered just after a falling edge, returns just after the next one.
    task automatic tick(input logic v, input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] data, input bit rst_after);
        logic acc;
        check("req_ready", {31'b0, Req_ready}, {31'b0, exp_ready});
        Req_valid    = v;
        Req_we       = we;
        Req_size     = sz;
        Req_signed   = sgn;
        Data_address = addr;
        Data_in      = data;
        acc = v & exp_ready;
        @(posedge Clk);
        edges++;
        if (acc) model_req(we, sz, sgn, addr, data);
        if (init_left > 0) begin
            init_left--;
            if (init_left == 0) exp_ready = 1'b1;
        end
        if (rst_after) begin
            #1;
            Rst_n = 1'b0;
            exp_q.delete();
            exp_ready = 1'b0;
        end
        @(negedge Clk);
        check_rsp();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] sz, input logic sgn, input logic [31:0] addr);
        tick(1'b1, 1'b0, sz, sgn, addr, 32'h0, 1'b0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] data);
        tick(1'b1, 1'b1, sz, 1'b0, addr, data, 1'b0);
    endtask

    // Called with Rst_n already low; holds it a few cycles and releases on a falling edge.
    task automatic hold_and_release();
        #1;
        check("rst_ready", {31'b0, Req_ready}, 32'h0);
        check("rst_valid", {31'b0, Rsp_valid}, 32'h0);
        check("rst_err", {31'b0, Rsp_err}, 32'h0);
        check("rst_data", Data_out, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("rst_hold_valid", {31'b0, Rsp_valid}, 32'h0);
            check("rst_hold_ready", {31'b0, Req_ready}, 32'h0);
        end
        Rst_n = 1'b1;
        exp_q.delete();
        clear_model();
        init_left = DEPTH;
        exp_ready = 1'b0;
    endtask

    initial begin
        Rst_n        = 1'b0;
        Req_valid    = 1'b0;
        Req_we       = 1'b0;
        Req_size     = 2'd0;
        Req_signed   = 1'b0;
        Data_address = 32'h0;
        Data_in      = 32'h0;
        #12;
        @(negedge Clk);
        hold_and_release();

        // Init sweep: requests offered early must be ignored, ready rises after DEPTH cycles.
        for (int i = 0; i < 20; i++) tick(1'b1, 1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 1'b0);
        idle(DEPTH - 20);
        ld(2'd2, 1'b0, 32'h1000);
        idle(LAT + 1);

        st(2'd2, 32'h1000, 32'hFFFF_FFFF);
        ld(2'd2, 1'b0, 32'h1000);
        idle(LAT + 1);

        st(2'd2, 32'h1000, 32'h0000_0000);
        st(2'd1, 32'h1002, 32'h0000_AAAA);
        ld(2'd0, 1'b1, 32'h1003);
        ld(2'd1, 1'b0, 32'h1002);
        ld(2'd2, 1'b0, 32'h1000);
        ld(2'd1, 1'b1, 32'h1002);
        ld(2'd0, 1'b0, 32'h1002);
        idle(LAT + 1);

        ld(2'd2, 1'b0, 32'h1001);
        st(2'd1, 32'h1003, 32'h0000_5555);
        ld(2'd2, 1'b0, 32'h4000);
        ld(2'd3, 1'b0, 32'h1000);
        st(2'd0, 32'h3FFF, 32'h0000_0077);
        ld(2'd0, 1'b0, 32'h3FFF);
        ld(2'd2, 1'b0, 32'h1000);
        idle(LAT + 1);

        for (int i = 0; i < 50; i++) st(2'd2, 32'h1000 + 32'(4 * i), $urandom);
        for (int i = 0; i < 50; i++) ld(2'd2, 1'b0, 32'h1000 + 32'(4 * i));
        idle(LAT + 1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 32'h5000))
                                              : 32'h1000 + 32'($urandom_range(0, 63));
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        end
        idle(LAT + 1);

        // Reset with two loads in flight: neither response may appear.
        ld(2'd2, 1'b0, 32'h1000);
        tick(1'b1, 1'b0, 2'd2, 1'b0, 32'h1004, 32'h0, 1'b1);
        hold_and_release();

        // Reset part-way through the sweep: the full sweep must restart.
        idle(100);
        tick(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b1);
        hold_and_release();
        idle(DEPTH);
        ld(2'd2, 1'b0, 32'h1000);
        ld(2'd2, 1'b0, 32'h10C4);
        idle(LAT + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
